// File: rtl/cache_pkg.sv
// Shared widths, line types and refill FSM encoding for the cache refill path.
package cache_pkg;

  localparam int SetWidth      = 4;
  localparam int TagWidth      = 8;
  localparam int DataWidth     = 32;
  localparam int Associativity = 4;
  localparam int WayWidth      = $clog2(Associativity);

  typedef struct packed {
    logic                valid;
    logic [TagWidth-1:0] tag;
  } block_info_t;

  typedef logic [DataWidth-1:0] block_data_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE
  } refill_state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way choice: matching valid tag first, then lowest invalid way, then round-robin.
module cache_victim_sel
  import cache_pkg::*;
(
  input  block_info_t         i_info [Associativity],
  input  logic [TagWidth-1:0] i_tag,
  input  logic [WayWidth-1:0] i_rr_ptr,
  output logic [WayWidth-1:0] o_way,
  output logic                o_use_rr
);

  logic                w_hit;
  logic [WayWidth-1:0] w_hit_way;
  logic                w_free;
  logic [WayWidth-1:0] w_free_way;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int i = Associativity - 1; i >= 0; i--) begin
      if (i_info[i].valid && (i_info[i].tag == i_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WayWidth'(i);
      end
      if (!i_info[i].valid) begin
        w_free     = 1'b1;
        w_free_way = WayWidth'(i);
      end
    end
  end

  always_comb begin
    o_use_rr = 1'b0;
    if (w_hit) begin
      o_way = w_hit_way;
    end else if (w_free) begin
      o_way = w_free_way;
    end else begin
      o_way    = i_rr_ptr;
      o_use_rr = 1'b1;
    end
  end

endmodule

// File: rtl/cache_refill.sv
// Miss refill engine: latches a missing set, fetches the block from memory and writes back the whole set.
module cache_refill
  import cache_pkg::*;
#(
  parameter int TimeoutCycles = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         miss_valid_i,
  output logic                         miss_ready_o,
  input  logic [SetWidth-1:0]          miss_set_i,
  input  logic [TagWidth-1:0]          miss_tag_i,
  input  block_info_t                  miss_line_info_i [Associativity],
  input  block_data_t                  miss_line_data_i [Associativity],
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [TagWidth+SetWidth-1:0] mem_req_addr_o,
  input  logic                         mem_resp_valid_i,
  input  logic [DataWidth-1:0]         mem_resp_data_i,
  output logic                         write_en_o,
  output logic [SetWidth-1:0]          write_set_o,
  output block_info_t                  write_set_info_o [Associativity],
  output block_data_t                  write_set_data_o [Associativity],
  output logic                         fill_done_o,
  output logic [DataWidth-1:0]         fill_data_o,
  output logic                         timeout_o
);

  localparam logic [15:0] WaitLast = 16'(TimeoutCycles - 1);
  localparam logic [WayWidth-1:0] RrLast = WayWidth'(Associativity - 1);

  refill_state_e                  r_state;
  logic [SetWidth-1:0]            r_set;
  logic [TagWidth-1:0]            r_tag;
  block_info_t                    r_info [Associativity];
  block_data_t                    r_data [Associativity];
  logic [WayWidth-1:0]            r_rr_ptr;
  logic [15:0]                    r_wait_cnt;
  logic                           r_used_rr;
  logic                           r_miss_ready;
  logic                           r_req_valid;
  logic [TagWidth+SetWidth-1:0]   r_req_addr;
  logic                           r_write_en;
  logic [SetWidth-1:0]            r_write_set;
  block_info_t                    r_write_info [Associativity];
  block_data_t                    r_write_data [Associativity];
  logic                           r_fill_done;
  logic [DataWidth-1:0]           r_fill_data;
  logic                           r_timeout;

  logic [WayWidth-1:0]            w_victim;
  logic                           w_use_rr;
  block_info_t                    w_new_info [Associativity];
  block_data_t                    w_new_data [Associativity];

  cache_victim_sel u_victim_sel (
    .i_info   (r_info),
    .i_tag    (r_tag),
    .i_rr_ptr (r_rr_ptr),
    .o_way    (w_victim),
    .o_use_rr (w_use_rr)
  );

  always_comb begin
    for (int i = 0; i < Associativity; i++) begin
      w_new_info[i] = r_info[i];
      w_new_data[i] = r_data[i];
      if (WayWidth'(i) == w_victim) begin
        w_new_info[i] = '{valid: 1'b1, tag: r_tag};
        w_new_data[i] = mem_resp_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_set        <= '0;
      r_tag        <= '0;
      r_rr_ptr     <= '0;
      r_wait_cnt   <= '0;
      r_used_rr    <= 1'b0;
      r_miss_ready <= 1'b0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_write_en   <= 1'b0;
      r_write_set  <= '0;
      r_fill_done  <= 1'b0;
      r_fill_data  <= '0;
      r_timeout    <= 1'b0;
      for (int i = 0; i < Associativity; i++) begin
        r_info[i]       <= '0;
        r_data[i]       <= '0;
        r_write_info[i] <= '0;
        r_write_data[i] <= '0;
      end
    end else begin
      r_write_en  <= 1'b0;
      r_fill_done <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miss_ready <= 1'b1;
          if (r_miss_ready && miss_valid_i) begin
            r_miss_ready <= 1'b0;
            r_set        <= miss_set_i;
            r_tag        <= miss_tag_i;
            for (int i = 0; i < Associativity; i++) begin
              r_info[i] <= miss_line_info_i[i];
              r_data[i] <= miss_line_data_i[i];
            end
            r_req_valid <= 1'b1;
            r_req_addr  <= {miss_tag_i, miss_set_i};
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_wait_cnt  <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          // A response on the terminal-count cycle takes priority over the abort.
          if (mem_resp_valid_i) begin
            r_write_en  <= 1'b1;
            r_fill_done <= 1'b1;
            r_write_set <= r_set;
            r_fill_data <= mem_resp_data_i;
            r_used_rr   <= w_use_rr;
            for (int i = 0; i < Associativity; i++) begin
              r_write_info[i] <= w_new_info[i];
              r_write_data[i] <= w_new_data[i];
            end
            r_state <= WRITE;
          end else if (r_wait_cnt == WaitLast) begin
            r_timeout    <= 1'b1;
            r_miss_ready <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        WRITE: begin
          r_write_set <= '0;
          r_fill_data <= '0;
          for (int i = 0; i < Associativity; i++) begin
            r_write_info[i] <= '0;
            r_write_data[i] <= '0;
          end
          if (r_used_rr) begin
            r_rr_ptr <= (r_rr_ptr == RrLast) ? '0 : r_rr_ptr + 1'b1;
          end
          r_used_rr    <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miss_ready_o     = r_miss_ready;
  assign mem_req_valid_o  = r_req_valid;
  assign mem_req_addr_o   = r_req_addr;
  assign write_en_o       = r_write_en;
  assign write_set_o      = r_write_set;
  assign write_set_info_o = r_write_info;
  assign write_set_data_o = r_write_data;
  assign fill_done_o      = r_fill_done;
  assign fill_data_o      = r_fill_data;
  assign timeout_o        = r_timeout;

endmodule

// File: tb/tb_cache_refill.sv
// Randomized scoreboard bench for cache_refill with a set-level reference model.
module tb_cache_refill;
  import cache_pkg::*;

  localparam int A      = Associativity;
  localparam int TO_CYC = 8;

  typedef block_info_t [A-1:0] info_arr_t;
  typedef block_data_t [A-1:0] data_arr_t;

  typedef struct {
    bit                  is_timeout;
    logic [SetWidth-1:0] set;
    info_arr_t           info;
    data_arr_t           data;
    block_data_t         fill;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         miss_valid = 1'b0;
  logic                         miss_ready;
  logic [SetWidth-1:0]          miss_set = '0;
  logic [TagWidth-1:0]          miss_tag = '0;
  block_info_t                  miss_info [A];
  block_data_t                  miss_data [A];
  logic                         req_valid;
  logic                         req_ready = 1'b0;
  logic [TagWidth+SetWidth-1:0] req_addr;
  logic                         resp_valid = 1'b0;
  logic [DataWidth-1:0]         resp_data = '0;
  logic                         wr_en;
  logic [SetWidth-1:0]          wr_set;
  block_info_t                  wr_info [A];
  block_data_t                  wr_data [A];
  logic                         fill_done;
  logic [DataWidth-1:0]         fill_data;
  logic                         tmo;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   m_rr = 0;
  exp_t exp_q[$];

  cache_refill #(.TimeoutCycles(TO_CYC)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .miss_valid_i     (miss_valid),
    .miss_ready_o     (miss_ready),
    .miss_set_i       (miss_set),
    .miss_tag_i       (miss_tag),
    .miss_line_info_i (miss_info),
    .miss_line_data_i (miss_data),
    .mem_req_valid_o  (req_valid),
    .mem_req_ready_i  (req_ready),
    .mem_req_addr_o   (req_addr),
    .mem_resp_valid_i (resp_valid),
    .mem_resp_data_i  (resp_data),
    .write_en_o       (wr_en),
    .write_set_o      (wr_set),
    .write_set_info_o (wr_info),
    .write_set_data_o (wr_data),
    .fill_done_o      (fill_done),
    .fill_data_o      (fill_data),
    .timeout_o        (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per write or timeout event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_en || fill_done || tmo) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {wr_en, fill_done, tmo}, 3'b000);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_timeout) begin
            chk("timeout_pulse", {wr_en, fill_done, tmo}, 3'b001);
          end else begin
            chk("write_pulse", {wr_en, fill_done, tmo}, 3'b110);
            chk("write_set", wr_set, e.set);
            chk("fill_data", fill_data, e.fill);
            for (int i = 0; i < A; i++) begin
              chk($sformatf("way%0d_info", i), wr_info[i], e.info[i]);
              chk($sformatf("way%0d_data", i), wr_data[i], e.data[i]);
            end
          end
        end
      end
      if (!req_valid) chk("idle_req_addr", req_addr, '0);
      if (!wr_en) chk("idle_write_bus", {wr_set, fill_data, wr_info[0], wr_data[A-1]}, '0);
    end
  end

  task automatic scramble();
    miss_set = SetWidth'($urandom);
    miss_tag = TagWidth'($urandom);
    for (int i = 0; i < A; i++) begin
      miss_info[i] = block_info_t'($urandom);
      miss_data[i] = $urandom;
    end
  endtask

  // One fill: model computes the outcome, driver performs handshakes with given stall/delay.
  task automatic do_fill(input logic [SetWidth-1:0] set, input logic [TagWidth-1:0] tag,
                         input info_arr_t info, input data_arr_t data,
                         input int stall, input int d, input block_data_t resp);
    exp_t e;
    int   v;
    int   n;
    bit   use_rr;
    v = -1;
    use_rr = 1'b0;
    for (int i = 0; i < A; i++) if (v < 0 && info[i].valid && info[i].tag == tag) v = i;
    for (int i = 0; i < A; i++) if (v < 0 && !info[i].valid) v = i;
    if (v < 0) begin
      v = m_rr;
      use_rr = 1'b1;
    end
    e.is_timeout = (d >= TO_CYC);
    e.set = set;
    e.info = info;
    e.data = data;
    e.info[v] = '{valid: 1'b1, tag: tag};
    e.data[v] = resp;
    e.fill = resp;
    if (!e.is_timeout && use_rr) m_rr = (m_rr + 1) % A;

    n = 0;
    while (!miss_ready && n < 20) begin
      tick();
      n++;
    end
    if (!miss_ready) begin
      chk("miss_ready_wait", miss_ready, 1'b1);
      return;
    end
    exp_q.push_back(e);
    miss_valid = 1'b1;
    miss_set = set;
    miss_tag = tag;
    for (int i = 0; i < A; i++) begin
      miss_info[i] = info[i];
      miss_data[i] = data[i];
    end
    tick();
    miss_valid = 1'b0;
    scramble();
    for (int k = 0; k < stall; k++) begin
      chk("req_hold", {req_valid, req_addr}, {1'b1, tag, set});
      chk("no_write_in_req", wr_en, 1'b0);
      resp_valid = $urandom_range(0, 1) == 1;
      resp_data = $urandom;
      tick();
    end
    resp_valid = 1'b0;
    chk("req_valid_addr", {req_valid, req_addr}, {1'b1, tag, set});
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    if (!e.is_timeout) begin
      repeat (d) tick();
      resp_valid = 1'b1;
      resp_data = resp;
      tick();
      resp_valid = 1'b0;
      resp_data = $urandom;
      chk("write_latency", wr_en, 1'b1);
    end else begin
      for (int k = 1; k <= TO_CYC; k++) begin
        tick();
        chk("timeout_timing", tmo, (k == TO_CYC));
      end
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
    end
  endtask

  function automatic info_arr_t rand_info();
    info_arr_t r;
    for (int i = 0; i < A; i++) r[i] = '{valid: ($urandom_range(0, 3) != 0), tag: TagWidth'($urandom_range(0, 5))};
    return r;
  endfunction

  function automatic data_arr_t rand_data();
    data_arr_t r;
    for (int i = 0; i < A; i++) r[i] = $urandom;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    info_arr_t info;
    data_arr_t data;
    scramble();
    repeat (3) tick();
    chk("rst_outputs", {miss_ready, req_valid, wr_en, fill_done, tmo}, 5'b0);
    chk("rst_addr", req_addr, '0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", miss_ready, 1'b1);

    // Two invalid ways: lowest one is the victim, pointer untouched.
    info = '{default: '0};
    info[1] = '{valid: 1'b1, tag: 8'h11};
    info[3] = '{valid: 1'b1, tag: 8'h22};
    data = rand_data();
    do_fill(4'd3, 8'h05, info, data, 0, 0, 32'hA5A5_0001);

    // Full set, no hit: round-robin 0,1,2,3 then wrap.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < A; i++) info[i] = '{valid: 1'b1, tag: 8'h40 + 8'(i)};
      do_fill(4'(j), 8'h99, info, rand_data(), 0, 0, $urandom);
    end

    // Tag already present in way 2: overwrite it, pointer stays put.
    for (int i = 0; i < A; i++) info[i] = '{valid: 1'b1, tag: 8'h60 + 8'(i)};
    do_fill(4'd7, 8'h62, info, rand_data(), 0, 1, $urandom);
    for (int i = 0; i < A; i++) info[i] = '{valid: 1'b1, tag: 8'h70 + 8'(i)};
    do_fill(4'd8, 8'h01, info, rand_data(), 0, 0, $urandom);

    // Request backpressure, response on the terminal count, and a plain timeout.
    do_fill(4'd9, 8'h33, rand_info(), rand_data(), 5, 2, $urandom);
    do_fill(4'd10, 8'h34, rand_info(), rand_data(), 0, TO_CYC - 1, $urandom);
    do_fill(4'd11, 8'h35, rand_info(), rand_data(), 1, TO_CYC, $urandom);

    // Reset while waiting for the response, then a stale response.
    miss_valid = 1'b1;
    miss_set = 4'd2;
    miss_tag = 8'h44;
    tick();
    miss_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midfill_rst_outputs", {miss_ready, req_valid, wr_en, fill_done, tmo}, 5'b0);
    tick();
    rst_n = 1'b1;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("ready_after_midfill_rst", miss_ready, 1'b1);
    m_rr = 0;
    repeat (TO_CYC + 4) tick();

    for (int j = 0; j < 60; j++) begin
      do_fill(SetWidth'($urandom), TagWidth'($urandom_range(0, 5)), rand_info(), rand_data(),
              $urandom_range(0, 3), $urandom_range(0, TO_CYC + 1), $urandom);
    end

    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 Parameter TimeoutCycles, default 256: the block SHALL abort a fill when WAIT lasts this many cycles; legal range is 2..65535.
REQ-002 All other widths and types SHALL come from cache_pkg: SetWidth, TagWidth, DataWidth, Associativity, WayWidth, block_info_t {valid, tag}, block_data_t.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low. Clock and reset ports are clk_i and rst_ni, listed first.
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 miss_valid_i  in  1  miss request from the lookup stage.
REQ-007 miss_ready_o  out  1  refill engine can accept a miss.
REQ-008 miss_set_i  in  SetWidth  set index of the miss.
REQ-009 miss_tag_i  in  TagWidth  tag of the miss.
REQ-010 miss_line_info_i  in  block_info_t[Associativity]  current info of all ways in the set.
REQ-011 miss_line_data_i  in  block_data_t[Associativity]  current data of all ways in the set.
REQ-012 mem_req_valid_o / mem_req_ready_i  out/in  1  backing-memory request handshake.
REQ-013 mem_req_addr_o  out  TagWidth+SetWidth  {tag, set} of the block to fetch.
REQ-014 mem_resp_valid_i  in  1  response beat valid; there is no backpressure on responses.
REQ-015 mem_resp_data_i  in  DataWidth  fetched block.
REQ-016 write_en_o, write_set_o, write_set_info_o, write_set_data_o  out  1/SetWidth/Associativity x info/Associativity x data  whole-set write port into the cache.
REQ-017 fill_done_o  out  1  one-cycle pulse when the fill is written.
REQ-018 fill_data_o  out  DataWidth  filled block; valid with fill_done_o.
REQ-019 timeout_o  out  1  one-cycle pulse when a fill is aborted.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and WRITE.
REQ-021 miss_ready_o SHALL be 1 only in IDLE.
REQ-022 When miss_valid_i is 1 in IDLE, the block SHALL register set, tag, line info and line data, and move to REQ on the next edge.
REQ-023 In REQ, mem_req_valid_o SHALL be 1 with mem_req_addr_o = {tag, set} held stable until mem_req_ready_i is 1; the block then moves to WAIT.
REQ-024 In WAIT, on mem_resp_valid_i the block SHALL capture mem_resp_data_i and move to WRITE.
REQ-025 mem_resp_valid_i SHALL be ignored in IDLE, REQ and WRITE.
REQ-026 In WRITE, for exactly one cycle:
- write_en_o = 1 and fill_done_o = 1.
- write_set_o = the captured set.
- write_set_info_o / write_set_data_o = the captured line with the victim way replaced by {valid=1, tag} and the fetched data.
- All other ways are passed through unchanged.
The block then returns to IDLE.
REQ-027 Victim selection SHALL be the lowest-index way with valid=0; if every way is valid, the victim is the way given by a global round-robin pointer.
REQ-028 The round-robin pointer SHALL be WayWidth bits, SHALL increment modulo Associativity only after a WRITE that used it, and SHALL wrap from Associativity-1 to 0.
REQ-029 If the captured line contains a valid way whose tag equals the miss tag, the block SHALL overwrite that way (no duplicate tags) and SHALL NOT advance the pointer.
REQ-030 A wait counter SHALL clear on entry to WAIT; if it reaches TimeoutCycles-1 without a response, the block SHALL pulse timeout_o, return to IDLE and perform no write.
REQ-031 Minimum latency with mem_req_ready_i=1 and a response on the first WAIT cycle is 3 cycles: accept at N, REQ at N+1, WAIT at N+2, write_en_o at N+3.
REQ-032 A response arriving on the same cycle as the timeout terminal count SHALL win: the block writes and does not pulse timeout_o.
REQ-033 Outside the states named above, all write_* outputs, fill_data_o and mem_req_addr_o SHALL be 0.

Reset
REQ-034 While rst_ni=0 the block SHALL be in IDLE with the pointer, wait counter and captured registers at 0.
REQ-035 During reset, miss_ready_o, mem_req_valid_o, write_en_o, fill_done_o and timeout_o SHALL be 0.
REQ-036 Reset asserted mid-fill SHALL abandon the fill with no write, and no timeout pulse SHALL be issued afterwards.

Structure
REQ-037 cache_pkg SHALL hold the widths, block_info_t, block_data_t and a new refill_state_e enum.
REQ-038 Victim selection SHALL be a sub-module, cache_victim_sel: a combinational priority encoder plus the round-robin fallback.

Verification
REQ-039 Associativity=4, set 3 with ways 0 and 2 invalid, miss tag 0x5 -> way 0 written {1,0x5}, ways 1-3 unchanged, pointer unchanged.
REQ-040 Four consecutive misses to a full set -> victims 0,1,2,3, then the pointer wraps to 0.
REQ-041 mem_req_ready_i low for 5 cycles -> mem_req_valid_o held with a stable address, and write_en_o is 0 throughout.
REQ-042 TimeoutCycles=8 with no response -> timeout_o pulses 8 cycles after WAIT entry and no write occurs; a response in the same cycle instead -> a write occurs and timeout_o stays 0.
REQ-043 rst_ni dropped in WAIT, then a late mem_resp_valid_i -> no write, miss_ready_o=1 one cycle after reset release.
REQ-044 Miss tag already present, valid, in way 2 -> way 2 rewritten and the pointer unchanged.
